// File: rtl/mcdf_arb_fmt.sv
// rtl/mcdf_arb_fmt.sv - MCDF channel arbiter and packet formatter
// Priority/round-robin arbitration over fill-level-eligible channels, then len-word packet send.
module mcdf_arb_fmt #(
    parameter int CH_NUM       = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int PRIO_WIDTH   = 2,
    parameter int LEN_WIDTH    = 3,
    parameter int MAX_LEN_CODE = 3,
    parameter int CNT_WIDTH    = 8,
    parameter int CHID_WIDTH   = 2,
    parameter int IFG          = 1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [CH_NUM-1:0]              slv_en_i,
    input  logic [CH_NUM*PRIO_WIDTH-1:0]   slv_prio_i,
    input  logic [CH_NUM*LEN_WIDTH-1:0]    slv_pkglen_i,
    input  logic [CH_NUM*CNT_WIDTH-1:0]    slv_count_i,
    input  logic [CH_NUM*DATA_WIDTH-1:0]   slv_data_i,
    output logic [CH_NUM-1:0]              slv_ack_o,
    output logic                           fmt_req_o,
    input  logic                           fmt_grant_i,
    output logic [CHID_WIDTH-1:0]          fmt_chid_o,
    output logic [CNT_WIDTH-1:0]           fmt_length_o,
    output logic [DATA_WIDTH-1:0]          fmt_data_o,
    output logic                           fmt_start_o,
    output logic                           fmt_end_o
);
    localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

    state_t                  state;
    logic [CHID_WIDTH-1:0]   rr_ptr;
    logic [CNT_WIDTH-1:0]    beat;
    logic [GAP_W-1:0]        gap_cnt;
    logic [CNT_WIDTH-1:0]    len_arr [CH_NUM];
    logic [CH_NUM-1:0]       eligible;
    logic                    any_elig;
    logic [CHID_WIDTH-1:0]   win_id;
    logic [CNT_WIDTH-1:0]    win_len;
    logic [PRIO_WIDTH-1:0]   best_prio;
    logic [PRIO_WIDTH-1:0]   cur_prio;
    int                      idx;
    logic [DATA_WIDTH-1:0]   head;
    logic                    last_beat;

    function automatic logic [CNT_WIDTH-1:0] decode_len(input logic [LEN_WIDTH-1:0] code);
        int sat;
        sat = (int'(code) > MAX_LEN_CODE) ? MAX_LEN_CODE : int'(code);
        return CNT_WIDTH'(1) << (sat + 2);
    endfunction

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            len_arr[i]  = decode_len(slv_pkglen_i[i*LEN_WIDTH +: LEN_WIDTH]);
            eligible[i] = slv_en_i[i] && (slv_count_i[i*CNT_WIDTH +: CNT_WIDTH] >= len_arr[i]);
        end
    end

    // Scan in round-robin order starting after rr_ptr; strict '<' keeps the earliest of equal priorities.
    always_comb begin
        any_elig  = 1'b0;
        win_id    = '0;
        win_len   = '0;
        best_prio = '0;
        cur_prio  = '0;
        idx       = 0;
        for (int k = 1; k <= CH_NUM; k++) begin
            idx      = (int'(rr_ptr) + k) % CH_NUM;
            cur_prio = slv_prio_i[idx*PRIO_WIDTH +: PRIO_WIDTH];
            if (eligible[idx] && (!any_elig || cur_prio < best_prio)) begin
                any_elig  = 1'b1;
                best_prio = cur_prio;
                win_id    = CHID_WIDTH'(idx);
                win_len   = len_arr[idx];
            end
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (fmt_chid_o == CHID_WIDTH'(i)) begin
                head = slv_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign last_beat = (beat == fmt_length_o - CNT_WIDTH'(1));
    assign slv_ack_o = (state == SEND) ? (CH_NUM'(1) << fmt_chid_o) : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            rr_ptr       <= CHID_WIDTH'(CH_NUM - 1);
            beat         <= '0;
            gap_cnt      <= '0;
            fmt_req_o    <= 1'b0;
            fmt_chid_o   <= '0;
            fmt_length_o <= '0;
            fmt_data_o   <= '0;
            fmt_start_o  <= 1'b0;
            fmt_end_o    <= 1'b0;
        end else begin
            fmt_start_o <= 1'b0;
            fmt_end_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        fmt_chid_o   <= win_id;
                        fmt_length_o <= win_len;
                        rr_ptr       <= win_id;
                        fmt_req_o    <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (fmt_grant_i) begin
                        fmt_req_o <= 1'b0;
                        beat      <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    fmt_data_o  <= head;
                    fmt_start_o <= (beat == '0);
                    fmt_end_o   <= last_beat;
                    beat        <= beat + CNT_WIDTH'(1);
                    if (last_beat) begin
                        gap_cnt <= '0;
                        state   <= (IFG > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(IFG - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcdf_arb_fmt.sv
// tb/tb_mcdf_arb_fmt.sv - directed self-checking bench for mcdf_arb_fmt
// Second instance with IFG=0 shares all inputs for the back-to-back case.
module tb_mcdf_arb_fmt;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [3:0]  en;
    logic [1:0]  prio   [4];
    logic [2:0]  pkglen [4];
    logic [7:0]  count  [4];
    logic [23:0] pop_cnt [4];
    logic        grant;

    logic [7:0]   slv_prio_i;
    logic [11:0]  slv_pkglen_i;
    logic [31:0]  slv_count_i;
    logic [127:0] slv_data_i;

    logic [3:0]  slv_ack_o, f0_ack;
    logic        fmt_req_o, f0_req;
    logic [1:0]  fmt_chid_o, f0_chid;
    logic [7:0]  fmt_length_o, f0_len;
    logic [31:0] fmt_data_o, f0_data;
    logic        fmt_start_o, f0_start;
    logic        fmt_end_o, f0_end;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    assign slv_prio_i   = {prio[3], prio[2], prio[1], prio[0]};
    assign slv_pkglen_i = {pkglen[3], pkglen[2], pkglen[1], pkglen[0]};
    assign slv_count_i  = {count[3], count[2], count[1], count[0]};
    assign slv_data_i   = {8'd3, pop_cnt[3], 8'd2, pop_cnt[2], 8'd1, pop_cnt[1], 8'd0, pop_cnt[0]};

    // Show-ahead FIFO model: head word advances after each pop by the IFG=1 instance.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < 4; c++) pop_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < 4; c++) if (slv_ack_o[c]) pop_cnt[c] <= pop_cnt[c] + 24'd1;
        end
    end

    mcdf_arb_fmt #(.IFG(1)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .slv_en_i(en), .slv_prio_i(slv_prio_i),
        .slv_pkglen_i(slv_pkglen_i), .slv_count_i(slv_count_i), .slv_data_i(slv_data_i),
        .slv_ack_o(slv_ack_o), .fmt_req_o(fmt_req_o), .fmt_grant_i(grant),
        .fmt_chid_o(fmt_chid_o), .fmt_length_o(fmt_length_o), .fmt_data_o(fmt_data_o),
        .fmt_start_o(fmt_start_o), .fmt_end_o(fmt_end_o)
    );

    mcdf_arb_fmt #(.IFG(0)) dut0 (
        .clk_i(clk_i), .rstn_i(rstn_i), .slv_en_i(en), .slv_prio_i(slv_prio_i),
        .slv_pkglen_i(slv_pkglen_i), .slv_count_i(slv_count_i), .slv_data_i(slv_data_i),
        .slv_ack_o(f0_ack), .fmt_req_o(f0_req), .fmt_grant_i(grant),
        .fmt_chid_o(f0_chid), .fmt_length_o(f0_len), .fmt_data_o(f0_data),
        .fmt_start_o(f0_start), .fmt_end_o(f0_end)
    );

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        en = '0;
        grant = 1'b0;
        for (int c = 0; c < 4; c++) begin
            prio[c] = '0;
            pkglen[c] = '0;
            count[c] = '0;
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        clear_inputs();
        repeat (2) step();
        rstn_i = 1'b1;
        step();
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!fmt_req_o && n < 100) begin
            step();
            n++;
        end
        tests++;
        if (fmt_req_o !== 1'b1) begin
            fails++;
            $display("FAIL %s: fmt_req_o=%b, required 1 within 100 cycles", name, fmt_req_o);
        end
    endtask

    task automatic check_chid_len(input string name, input logic [1:0] ch, input logic [7:0] len);
        tests++;
        if (fmt_chid_o !== ch || fmt_length_o !== len) begin
            fails++;
            $display("FAIL %s: chid=%0d length=%0d, required chid=%0d length=%0d",
                     name, fmt_chid_o, fmt_length_o, ch, len);
        end
    endtask

    // Grant at this negedge, then check len ack cycles and the lagging data/start/end words.
    task automatic grant_and_check(input int ch, input int len, input int first, input string name);
        logic [3:0]  exp_ack;
        logic [31:0] exp_d;
        grant = 1'b1;
        step();
        grant = 1'b0;
        for (int k = 0; k <= len; k++) begin
            exp_ack = (k < len) ? 4'(1 << ch) : 4'b0;
            tests++;
            if (slv_ack_o !== exp_ack) begin
                fails++;
                $display("FAIL %s ack beat %0d: got %b, required %b", name, k, slv_ack_o, exp_ack);
            end
            if (k >= 1) begin
                exp_d = {8'(ch), 24'(first + k - 1)};
                tests++;
                if (fmt_data_o !== exp_d || fmt_start_o !== (k == 1) || fmt_end_o !== (k == len)) begin
                    fails++;
                    $display("FAIL %s word %0d: data=%h start=%b end=%b, required data=%h start=%b end=%b",
                             name, k - 1, fmt_data_o, fmt_start_o, fmt_end_o, exp_d, k == 1, k == len);
                end
            end
            if (k < len) step();
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        clear_inputs();
        step();
        tests++;
        if ({fmt_req_o, slv_ack_o, fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o} !== '0 ||
            {f0_req, f0_ack, f0_chid, f0_len, f0_data, f0_start, f0_end} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: req=%b ack=%b chid=%0d len=%0d data=%h, required all 0",
                     fmt_req_o, slv_ack_o, fmt_chid_o, fmt_length_o, fmt_data_o);
        end
        rstn_i = 1'b1;
        en = 4'b1111;
        repeat (6) step();
        tests++;
        if (fmt_req_o !== 1'b0 || slv_ack_o !== 4'b0) begin
            fails++;
            $display("FAIL count_zero_idle: req=%b ack=%b, required req=0 ack=0000", fmt_req_o, slv_ack_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        en = 4'b0010;
        count[1] = 8'd4;
        wait_req("single_req");
        check_chid_len("single_latch", 2'd1, 8'd4);
        step();
        tests++;
        if (fmt_req_o !== 1'b1 || slv_ack_o !== 4'b0) begin
            fails++;
            $display("FAIL single_hold: req=%b ack=%b, required req=1 ack=0000", fmt_req_o, slv_ack_o);
        end
        en = 4'b0000;
        grant_and_check(1, 4, 0, "single");
        step();
        tests++;
        if (fmt_req_o !== 1'b0 || fmt_end_o !== 1'b0 || slv_ack_o !== 4'b0) begin
            fails++;
            $display("FAIL single_gap: req=%b end=%b ack=%b, required 0 0 0000", fmt_req_o, fmt_end_o, slv_ack_o);
        end
        repeat (4) step();
        tests++;
        if (fmt_req_o !== 1'b0 || fmt_data_o !== {8'd1, 24'd3} || fmt_chid_o !== 2'd1) begin
            fails++;
            $display("FAIL single_hold_after: req=%b data=%h chid=%0d, required 0 01000003 1",
                     fmt_req_o, fmt_data_o, fmt_chid_o);
        end
    endtask

    task automatic test_priority();
        do_reset();
        en = 4'b0101;
        prio[0] = 2'd2;
        prio[2] = 2'd0;
        count[0] = 8'd4;
        count[2] = 8'd4;
        wait_req("prio_req_a");
        check_chid_len("prio_first", 2'd2, 8'd4);
        en = 4'b0001;
        grant_and_check(2, 4, 0, "prio_a");
        wait_req("prio_req_b");
        check_chid_len("prio_second", 2'd0, 8'd4);
        en = 4'b0000;
        grant_and_check(0, 4, 0, "prio_b");
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int npk [4] = '{0, 0, 0, 0};
        do_reset();
        en = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            prio[c] = 2'd1;
            count[c] = 8'd4;
        end
        for (int i = 0; i < 5; i++) begin
            wait_req("rr_req");
            check_chid_len("rr_order", 2'(order[i]), 8'd4);
            grant_and_check(order[i], 4, npk[order[i]] * 4, "rr");
            npk[order[i]]++;
        end
    endtask

    task automatic test_saturation();
        int seen = 0;
        do_reset();
        en = 4'b0001;
        pkglen[0] = 3'd7;
        count[0] = 8'd31;
        repeat (10) begin
            step();
            if (fmt_req_o) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL sat_below: req cycles=%0d, required 0", seen);
        end
        count[0] = 8'd32;
        wait_req("sat_req");
        check_chid_len("sat_latch", 2'd0, 8'd32);
        en = 4'b0000;
        grant_and_check(0, 32, 0, "sat");
    endtask

    task automatic test_stall_reset();
        int bad = 0;
        do_reset();
        en = 4'b1000;
        pkglen[3] = 3'd1;
        count[3] = 8'd8;
        wait_req("stall_req");
        check_chid_len("stall_latch", 2'd3, 8'd8);
        repeat (20) begin
            step();
            if (fmt_req_o !== 1'b1 || slv_ack_o !== 4'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_hold: bad cycles=%0d, required 0", bad);
        end
        grant = 1'b1;
        step();
        grant = 1'b0;
        repeat (2) step();
        #2 rstn_i = 1'b0;
        #1;
        tests++;
        if ({fmt_req_o, slv_ack_o, fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o} !== '0) begin
            fails++;
            $display("FAIL async_reset: req=%b ack=%b chid=%0d len=%0d data=%h start=%b end=%b, required all 0",
                     fmt_req_o, slv_ack_o, fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o);
        end
        repeat (2) step();
        rstn_i = 1'b1;
        wait_req("restart_req");
        check_chid_len("restart_latch", 2'd3, 8'd8);
        en = 4'b0000;
        grant_and_check(3, 8, 0, "restart");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        en = 4'b0011;
        count[0] = 8'd4;
        count[1] = 8'd4;
        grant = 1'b1;
        while (!f0_end && n < 50) begin
            step();
            n++;
        end
        tests++;
        if (f0_end !== 1'b1 || f0_req !== 1'b0 || f0_chid !== 2'd0) begin
            fails++;
            $display("FAIL b2b_end_a: end=%b req=%b chid=%0d, required end=1 req=0 chid=0", f0_end, f0_req, f0_chid);
        end
        step();
        tests++;
        if (f0_req !== 1'b1 || f0_chid !== 2'd1 || fmt_req_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_req_b: ifg0 req=%b chid=%0d ifg1 req=%b, required 1 1 0", f0_req, f0_chid, fmt_req_o);
        end
        grant = 1'b0;
        en = 4'b0000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_saturation();
        test_stall_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
